// File: rtl/hex_scan.sv
// Multiplexed driver for a bank of common-anode 7-segment digits sharing one active-low segment bus.
// Latches a packed hex value on a load strobe and scans it with per-digit blink, leading-zero blanking and a ghosting guard.
module hex_scan #(
  parameter int DIGITS    = 8,
  parameter int DIV       = 50000,
  parameter int GUARD     = 4,
  parameter int BLINK_DIV = 250
) (
  input  logic                                          iClk,
  input  logic                                          iRst,
  input  logic                                          iLoad,
  input  logic [4*DIGITS-1:0]                           iNum,
  input  logic [DIGITS-1:0]                             iDot,
  input  logic [DIGITS-1:0]                             iBlink,
  input  logic                                          iLzb,
  output logic [7:0]                                    oHex,
  output logic [DIGITS-1:0]                             oSel,
  output logic [$clog2(DIGITS > 1 ? DIGITS : 2)-1:0]    oDigit
);

  localparam int IW = $clog2(DIGITS > 1 ? DIGITS : 2);
  localparam int PW = $clog2(DIV > 1 ? DIV : 2);
  localparam int RW = $clog2(BLINK_DIV > 1 ? BLINK_DIV : 2);

  logic [4*DIGITS-1:0] r_num;
  logic [DIGITS-1:0]   r_dot;
  logic [DIGITS-1:0]   r_blink;
  logic                r_lzb;

  logic [PW-1:0]       r_pcnt;
  logic [IW-1:0]       r_idx;
  logic [RW-1:0]       r_rcnt;
  logic                r_ph;

  logic [7:0]          r_hex;
  logic [DIGITS-1:0]   r_sel;
  logic [IW-1:0]       r_digit;

  logic                w_lastPcnt;
  logic                w_lastIdx;
  logic                w_lastRound;
  logic                w_guard;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_zeroFrom;
  logic                w_blank;
  logic                w_blinkOff;
  logic [6:0]          w_seg;
  logic [7:0]          w_hexNext;
  logic [DIGITS-1:0]   w_selNext;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b0100111;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_lastPcnt  = (r_pcnt == PW'(DIV - 1));
  assign w_lastIdx   = (r_idx == IW'(DIGITS - 1));
  assign w_lastRound = (r_rcnt == RW'(BLINK_DIV - 1));

  generate
    if (GUARD == 0) begin : g_noGuard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_pcnt < PW'(GUARD));
    end
  endgenerate

  // w_zeroFrom[k] is set when nibble k and every more significant nibble are zero
  always_comb begin
    logic acc;
    acc        = 1'b1;
    w_zeroFrom = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc           = acc & (r_num[4*k +: 4] == 4'h0);
      w_zeroFrom[k] = acc;
    end
  end

  assign w_nib      = r_num[{r_idx, 2'b00} +: 4];
  assign w_blank    = r_lzb && (r_idx != '0) && w_zeroFrom[r_idx];
  assign w_blinkOff = r_ph && r_blink[r_idx];
  assign w_seg      = w_blank ? 7'h7F : seg7(w_nib);

  always_comb begin
    w_hexNext = {~r_dot[r_idx], w_seg};
    w_selNext = ~(DIGITS'(1) << r_idx);
    if (w_guard) begin
      w_hexNext = 8'hFF;
      w_selNext = '1;
    end else if (w_blinkOff) begin
      w_hexNext = 8'hFF;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_num   <= '0;
      r_dot   <= '0;
      r_blink <= '0;
      r_lzb   <= 1'b0;
    end else if (iLoad) begin
      r_num   <= iNum;
      r_dot   <= iDot;
      r_blink <= iBlink;
      r_lzb   <= iLzb;
    end
  end

  // Blink phase only changes when the last slot of a round ends, so it never flips mid-slot
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
      r_rcnt <= '0;
      r_ph   <= 1'b0;
    end else begin
      r_pcnt <= w_lastPcnt ? '0 : r_pcnt + 1'b1;
      if (w_lastPcnt) begin
        r_idx <= w_lastIdx ? '0 : r_idx + 1'b1;
        if (w_lastIdx) begin
          if (w_lastRound) begin
            r_rcnt <= '0;
            r_ph   <= ~r_ph;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_hex   <= 8'hFF;
      r_sel   <= '1;
      r_digit <= '0;
    end else begin
      r_hex   <= w_hexNext;
      r_sel   <= w_selNext;
      r_digit <= r_idx;
    end
  end

  assign oHex   = r_hex;
  assign oSel   = r_sel;
  assign oDigit = r_digit;

endmodule

// File: doc/hex_scan.md
# hex_scan

Time-multiplexed driver for a bank of common-anode 7-segment digits plus decimal point, sharing one active-low segment bus. Latches a packed hexadecimal value on a load strobe and scans it one digit at a time through an active-low digit-select bus. Adds per-digit blink, leading-zero blanking and an inter-digit ghosting guard. Sits between the Nios II PIO / status registers and the board segment pins when digit count exceeds dedicated pin budget.

## Interface
- DIGITS, 8, number of scanned digits (1..16); digit 0 is least significant
- DIV, 50000, clock cycles per digit slot (DIV > GUARD)
- GUARD, 4, cycles at start of each slot with all digits off (0..DIV-1)
- BLINK_DIV, 250, full scan rounds per blink half-period (>= 1)

- iClk  in  1  system clock
- iRst  in  1  reset; synchronous, active-high
- iLoad  in  1  one-cycle strobe; captures iNum/iDot/iBlink/iLzb into shadow registers
- iNum  in  4*DIGITS  packed nibbles, digit k = iNum[4k+3:4k]
- iDot  in  DIGITS  decimal point request per digit, 1 = lit
- iBlink  in  DIGITS  blink enable per digit
- iLzb  in  1  leading-zero blanking enable
- oHex  out  8  segment bus, active-low; [7] = dot, [6:0] = g..a
- oSel  out  DIGITS  digit enables, active-low, at most one low
- oDigit  out  clog2(DIGITS) (min 1)  index of slot currently scanned

## Operation
- Segment encoding, 0..F active-low [6:0]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110. Dot bit [7] = ~dot.
- Shadow registers: iLoad high at edge captures all four inputs; without iLoad, shadow holds. Scanning uses shadow only.
- Prescaler pcnt: counts 0..DIV-1, wraps to 0. At pcnt = DIV-1, slot index idx advances (DIGITS-1 wraps to 0).
- Round counter rcnt: increments when idx wraps DIGITS-1 -> 0 with pcnt = DIV-1; at BLINK_DIV-1 wraps to 0 and toggles blink phase ph.
- Leading-zero blank for digit k (k >= 1): shadow iLzb = 1 and nibbles k..DIGITS-1 all zero. Digit 0 never blanked. Blanked digit forces [6:0] = 1111111; dot still honoured.
- Blink: ph = 1 and shadow iBlink[k] = 1 -> whole digit incl. dot = 8'hFF; oSel still asserted.
- Guard: pcnt < GUARD -> oSel all ones, oHex = 8'hFF.
- Otherwise oSel = ~(1 << idx), oHex = encoded digit idx.

## Timing
- Reset (iRst high at edge): pcnt = 0, idx = 0, rcnt = 0, ph = 0, shadow = all zero; outputs oHex = 8'hFF, oSel = all ones, oDigit = 0. Reset mid-scan aborts slot; restart from digit 0 with guard.
- oHex/oSel/oDigit registered: reflect state (pcnt, idx, ph, shadow) of the previous cycle, one-cycle latency.
- After reset release, first lit cycle: oSel[0] low GUARD+1 cycles after first non-reset edge (GUARD = 0: one cycle).
- Slot length exactly DIV cycles at outputs; lit portion DIV-GUARD cycles; full round DIGITS*DIV cycles.
- iLoad at edge t: shadow valid after t; visible on oHex no later than one cycle after digit's next lit cycle. iLoad during a lit slot updates that digit's segments mid-slot (accepted).
- iLoad and reset same edge: reset wins.
- Blink half-period = BLINK_DIV*DIGITS*DIV cycles; ph changes only at round boundary (never mid-slot).
- DIGITS = 1: idx fixed 0, rounds = slots.

## Test plan
- DIGITS=4, DIV=8, GUARD=2: reset, load iNum=16'h12A0 -> oSel cycles 1110,1101,1011,0111 each 6 lit cycles after 2 all-ones cycles; oHex = 1000000,0001000,0100100,1111001 (with [7]=1).
- iLzb=1, iNum=16'h0030, iDot=4'b0100 -> digits 3 blank (oHex 8'hFF), digit 2 oHex = 8'h7F, digit 1 = 8'hB0, digit 0 = 8'hC0; iNum=0 -> only digit 0 shows 8'hC0.
- BLINK_DIV=2, iBlink=4'b0001: digit 0 shows value for 2 rounds (64 cycles), 8'hFF for next 2; other digits unaffected.
- iNum driven with new value without iLoad -> oHex unchanged; one-cycle iLoad -> new value on next lit slot of each digit.
- Assert iRst mid-slot of digit 2 -> next cycle oHex=8'hFF, oSel=1111, oDigit=0; digit 0 lit GUARD+1 cycles after release.
- Every cycle: oSel has at most one zero; no zero during guard cycles.
